// File: rtl/fbuf_scanout.sv
// fbuf_scanout: free-running raster generator and framebuffer scan-out.
// Walks an h/v raster and issues one framebuffer read per active pixel.
// Sync/enable flags travel alongside the read, so the RGB332 data
// returning from the BRAM lines up with them. The data is expanded to
// RGB888 and registered together with the flags on the way out.
module fbuf_scanout #(
    parameter int FRAME_WIDTH_SCALED  = 640,
    parameter int FRAME_HEIGHT_SCALED = 480,
    parameter int H_FRONT             = 16,
    parameter int H_SYNC              = 96,
    parameter int H_BACK              = 48,
    parameter int V_FRONT             = 10,
    parameter int V_SYNC              = 2,
    parameter int V_BACK              = 33,
    parameter int FBUF_ADDR_WIDTH     = 19,
    parameter int FBUF_DATA_WIDTH     = 8,
    parameter int BRAM_LATENCY        = 2
) (
    input  logic                       vid_aclk,
    input  logic                       vid_areset,
    input  logic                       fbuf_rst_busy,
    output logic                       fbuf_en_rd,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr_rd,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data_rd,
    output logic [23:0]                vid_rgb,
    output logic                       vid_de,
    output logic                       vid_hsync,
    output logic                       vid_vsync,
    output logic                       vid_frame_start
);

    localparam int HT  = FRAME_WIDTH_SCALED + H_FRONT + H_SYNC + H_BACK;
    localparam int VT  = FRAME_HEIGHT_SCALED + V_FRONT + V_SYNC + V_BACK;
    localparam int HCW = $clog2(HT);
    localparam int VCW = $clog2(VT);
    localparam int AW  = FBUF_ADDR_WIDTH;

    // Total delay from sampling a raster position to its output register.
    localparam int D  = BRAM_LATENCY + 2;
    // The flag stages ahead of the output register; the output register is the last stage.
    localparam int NS = D - 1;

    localparam logic [HCW-1:0] H_LAST   = HCW'(HT - 1);
    localparam logic [HCW-1:0] H_ACTIVE = HCW'(FRAME_WIDTH_SCALED);
    localparam logic [HCW-1:0] HS_BEGIN = HCW'(FRAME_WIDTH_SCALED + H_FRONT);
    localparam logic [HCW-1:0] HS_END   = HCW'(FRAME_WIDTH_SCALED + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] V_LAST   = VCW'(VT - 1);
    localparam logic [VCW-1:0] V_ACTIVE = VCW'(FRAME_HEIGHT_SCALED);
    localparam logic [VCW-1:0] VS_BEGIN = VCW'(FRAME_HEIGHT_SCALED + V_FRONT);
    localparam logic [VCW-1:0] VS_END   = VCW'(FRAME_HEIGHT_SCALED + V_FRONT + V_SYNC);

    // Flag word bit positions.
    localparam int F_ACT   = 0;
    localparam int F_VALID = 1;
    localparam int F_HS    = 2;
    localparam int F_VS    = 3;
    localparam int F_FIRST = 4;
    // Cleared pipeline: nothing active or valid, syncs idle high.
    localparam logic [4:0] FLAGS_RST = 5'b01100;

    // RGB332 -> RGB888 by replicating the top bits of each channel.
    function automatic logic [23:0] expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6],
                d[4:2], d[4:2], d[4:3],
                d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

    logic [HCW-1:0] h_q, h_d;
    logic [VCW-1:0] v_q, v_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           en_rd_q, en_rd_d;
    logic [AW-1:0]  addr_rd_q, addr_rd_d;
    logic           active;
    logic [4:0]     stage0_flags;

    logic [4:0]     flags_q [NS];
    logic [4:0]     flags_d [NS];

    logic [23:0]    rgb_q, rgb_d;
    logic           de_q, de_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           frame_start_q, frame_start_d;

    // Raster counters, linear address counter and the registered read request.
    always_comb begin
        h_d       = h_q + HCW'(1);
        v_d       = v_q;
        addr_d    = addr_q;
        active    = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
        en_rd_d   = active && !fbuf_rst_busy;
        addr_rd_d = addr_rd_q;

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VCW'(1);
        end

        // The address advances on every active pixel, busy or not, and
        // rewinds only when the raster wraps to the top-left corner.
        if ((h_q == H_LAST) && (v_q == V_LAST)) begin
            addr_d = '0;
        end else if (active) begin
            addr_d = addr_q + AW'(1);
        end

        if (en_rd_d) begin
            addr_rd_d = addr_q;
        end

        stage0_flags          = '0;
        stage0_flags[F_ACT]   = active;
        stage0_flags[F_VALID] = active && !fbuf_rst_busy;
        stage0_flags[F_HS]    = !((h_q >= HS_BEGIN) && (h_q < HS_END));
        stage0_flags[F_VS]    = !((v_q >= VS_BEGIN) && (v_q < VS_END));
        stage0_flags[F_FIRST] = (h_q == '0) && (v_q == '0);
    end

    // Register the raster state and the read request.
    always_ff @(posedge vid_aclk or posedge vid_areset) begin
        if (vid_areset) begin
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            en_rd_q   <= 1'b0;
            addr_rd_q <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            en_rd_q   <= en_rd_d;
            addr_rd_q <= addr_rd_d;
        end
    end

    // Next value of each flag stage: stage 0 takes the live raster flags,
    // later stages take the stage in front of them.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_flag_stage
            if (gi == 0) begin : g_head
                assign flags_d[gi] = stage0_flags;
            end else begin : g_tail
                assign flags_d[gi] = flags_q[gi-1];
            end
        end
    endgenerate

    // Flag shift register; clearing it drops any BRAM data still in flight.
    always_ff @(posedge vid_aclk or posedge vid_areset) begin
        if (vid_areset) begin
            for (int i = 0; i < NS; i++) begin
                flags_q[i] <= FLAGS_RST;
            end
        end else begin
            flags_q <= flags_d;
        end
    end

    // Output stage: the last flag stage meets the returning pixel data here.
    always_comb begin
        de_d          = flags_q[NS-1][F_ACT];
        hsync_d       = flags_q[NS-1][F_HS];
        vsync_d       = flags_q[NS-1][F_VS];
        frame_start_d = flags_q[NS-1][F_FIRST] && flags_q[NS-1][F_ACT];
        rgb_d         = 24'h000000;
        if (flags_q[NS-1][F_VALID]) begin
            rgb_d = expand(fbuf_data_rd[7:0]);
        end
    end

    // Output register, so every video output comes straight from a flop.
    always_ff @(posedge vid_aclk or posedge vid_areset) begin
        if (vid_areset) begin
            rgb_q         <= 24'h000000;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fbuf_en_rd      = en_rd_q;
    assign fbuf_addr_rd    = addr_rd_q;
    assign vid_rgb         = rgb_q;
    assign vid_de          = de_q;
    assign vid_hsync       = hsync_q;
    assign vid_vsync       = vsync_q;
    assign vid_frame_start = frame_start_q;

endmodule
